// File: rtl/exec_pkg.sv
// Shared definitions for the sequential execution unit: opcode map, instruction
// field positions, flag bit indices and FSM state encoding.
package exec_pkg;

   localparam logic [4:0] OP_MOVSGPR = 5'd0;
   localparam logic [4:0] OP_MOV     = 5'd1;
   localparam logic [4:0] OP_ADD     = 5'd2;
   localparam logic [4:0] OP_SUB     = 5'd3;
   localparam logic [4:0] OP_MUL     = 5'd4;
   localparam logic [4:0] OP_ROR     = 5'd5;
   localparam logic [4:0] OP_RAND    = 5'd6;
   localparam logic [4:0] OP_RXOR    = 5'd7;
   localparam logic [4:0] OP_RXNOR   = 5'd8;
   localparam logic [4:0] OP_RNAND   = 5'd9;
   localparam logic [4:0] OP_RNOR    = 5'd10;
   localparam logic [4:0] OP_RNOT    = 5'd11;

   localparam int OPER_HI  = 31;
   localparam int OPER_LO  = 27;
   localparam int RDST_HI  = 26;
   localparam int RDST_LO  = 22;
   localparam int RSRC1_HI = 21;
   localparam int RSRC1_LO = 17;
   localparam int IMM_BIT  = 16;
   localparam int RSRC2_HI = 15;
   localparam int RSRC2_LO = 11;
   localparam int ISRC_HI  = 15;
   localparam int ISRC_LO  = 0;

   localparam int FLG_Z = 3;
   localparam int FLG_N = 2;
   localparam int FLG_C = 1;
   localparam int FLG_V = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_WB   = 2'd2
   } state_t;

   // The rsrc2 field aliases isrc, so it only names a register in register mode.
   function automatic logic uses_rsrc2(input logic [4:0] oper, input logic imm_mode);
      return !imm_mode && (oper inside {OP_ADD, OP_SUB, OP_MUL, OP_ROR, OP_RAND,
                                        OP_RXOR, OP_RXNOR, OP_RNAND, OP_RNOR});
   endfunction

endpackage

// File: rtl/seq_mul_unit.sv
// Unsigned shift-add multiplier: one add/shift iteration per cycle, DATA_W cycles
// per product; done marks the cycle whose closing edge completes the product.
module seq_mul_unit #(
   parameter int DATA_W = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [DATA_W-1:0]     a,
   input  logic [DATA_W-1:0]     b,
   output logic                  done,
   output logic [2*DATA_W-1:0]   product
);

   localparam int CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

   logic [DATA_W-1:0] mcand;
   logic [CNT_W-1:0]  cnt;
   logic              busy;
   logic [DATA_W:0]   partial;

   // Low half starts as the multiplier and drains out of bit 0 as the product fills in.
   assign partial = {1'b0, product[2*DATA_W-1:DATA_W]} + {1'b0, (product[0] ? mcand : '0)};
   assign done    = busy && (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         product <= '0;
         mcand   <= '0;
         cnt     <= '0;
         busy    <= 1'b0;
      end else if (start) begin
         product <= {{DATA_W{1'b0}}, b};
         mcand   <= a;
         cnt     <= '0;
         busy    <= 1'b1;
      end else if (busy) begin
         product <= {partial, product[DATA_W-1:1]};
         cnt     <= cnt + 1'b1;
         if (cnt == LAST) busy <= 1'b0;
      end
   end

endmodule

// File: rtl/seq_exec_unit.sv
// Clocked register-file ALU with valid/ready issue, multi-cycle multiply,
// status flags, illegal-instruction error pulse, write-back monitor and debug read.
module seq_exec_unit import exec_pkg::*; #(
   parameter int DATA_W = 16,
   parameter int NREG   = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       instr,
   input  logic              instr_valid,
   output logic              instr_ready,
   output logic              wb_valid,
   output logic [4:0]        wb_addr,
   output logic [DATA_W-1:0] wb_data,
   output logic [3:0]        flags,
   output logic              err,
   input  logic [4:0]        dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
   output logic [DATA_W-1:0] sgpr
);

   localparam int MSB = DATA_W - 1;

   logic [DATA_W-1:0] gpr [NREG];
   state_t            state;
   logic [4:0]        mul_rdst;

   logic [4:0]        oper, rdst, rsrc1, rsrc2;
   logic              imm_mode;
   logic [15:0]       isrc;
   logic [DATA_W-1:0] op_a, op_b, result;
   logic [DATA_W:0]   sum, diff;
   logic [3:0]        flags_nxt;
   logic              illegal, accept, mul_start, mul_done;
   logic [2*DATA_W-1:0] product;

   // Index fields are 5 bits but the file may be smaller; out-of-range reads give 0.
   function automatic logic [DATA_W-1:0] rd_gpr(input logic [4:0] idx);
      logic [DATA_W-1:0] val;
      val = '0;
      for (int i = 0; i < NREG; i++)
         if (idx == 5'(i)) val = gpr[i];
      return val;
   endfunction

   assign accept    = instr_valid && instr_ready;
   assign mul_start = accept && !illegal && (oper == OP_MUL);
   assign dbg_data  = rd_gpr(dbg_addr);

   always_comb begin
      // NOTE: every variable written here gets a default first so no latch is inferred.
      oper      = instr[OPER_HI:OPER_LO];
      rdst      = instr[RDST_HI:RDST_LO];
      rsrc1     = instr[RSRC1_HI:RSRC1_LO];
      imm_mode  = instr[IMM_BIT];
      rsrc2     = instr[RSRC2_HI:RSRC2_LO];
      isrc      = instr[ISRC_HI:ISRC_LO];
      op_a      = rd_gpr(rsrc1);
      op_b      = imm_mode ? DATA_W'(isrc) : rd_gpr(rsrc2);
      sum       = {1'b0, op_a} + {1'b0, op_b};
      diff      = {1'b0, op_a} - {1'b0, op_b};
      result    = '0;
      flags_nxt = '0;
      case (oper)
         OP_MOVSGPR: result = sgpr;
         OP_MOV:     result = imm_mode ? op_b : op_a;
         OP_ADD: begin
            result           = sum[MSB:0];
            flags_nxt[FLG_C] = sum[DATA_W];
            flags_nxt[FLG_V] = (op_a[MSB] == op_b[MSB]) && (result[MSB] != op_a[MSB]);
         end
         OP_SUB: begin
            result           = diff[MSB:0];
            flags_nxt[FLG_C] = diff[DATA_W];
            flags_nxt[FLG_V] = (op_a[MSB] != op_b[MSB]) && (result[MSB] != op_a[MSB]);
         end
         OP_ROR:   result = op_a | op_b;
         OP_RAND:  result = op_a & op_b;
         OP_RXOR:  result = op_a ^ op_b;
         OP_RXNOR: result = ~(op_a ^ op_b);
         OP_RNAND: result = ~(op_a & op_b);
         OP_RNOR:  result = ~(op_a | op_b);
         OP_RNOT:  result = imm_mode ? ~op_b : ~op_a;
         default:  result = '0;
      endcase
      flags_nxt[FLG_Z] = (result == '0);
      flags_nxt[FLG_N] = result[MSB];
      illegal = (oper > OP_RNOT) || (int'(rdst) >= NREG) || (int'(rsrc1) >= NREG) ||
                (uses_rsrc2(oper, imm_mode) && (int'(rsrc2) >= NREG));
   end

   seq_mul_unit #(.DATA_W(DATA_W)) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (mul_start),
      .a       (op_a),
      .b       (op_b),
      .done    (mul_done),
      .product (product)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         instr_ready <= 1'b1;
         wb_valid    <= 1'b0;
         wb_addr     <= '0;
         wb_data     <= '0;
         err         <= 1'b0;
         flags       <= '0;
         sgpr        <= '0;
         mul_rdst    <= '0;
         // NOTE: the register file is architecturally cleared by reset, so it lives in flops, not RAM.
         for (int i = 0; i < NREG; i++) gpr[i] <= '0;
      end else begin
         // NOTE: state uses non-blocking assignments so every read sees pre-edge values.
         wb_valid <= 1'b0;
         err      <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  if (illegal) begin
                     err <= 1'b1;
                  end else if (oper == OP_MUL) begin
                     state       <= ST_MUL;
                     instr_ready <= 1'b0;
                     mul_rdst    <= rdst;
                  end else begin
                     for (int i = 0; i < NREG; i++)
                        if (rdst == 5'(i)) gpr[i] <= result;
                     wb_valid <= 1'b1;
                     wb_addr  <= rdst;
                     wb_data  <= result;
                     if (oper != OP_MOVSGPR) flags <= flags_nxt;
                  end
               end
            end
            ST_MUL: begin
               if (mul_done) state <= ST_WB;
            end
            ST_WB: begin
               for (int i = 0; i < NREG; i++)
                  if (mul_rdst == 5'(i)) gpr[i] <= product[MSB:0];
               sgpr         <= product[2*DATA_W-1:DATA_W];
               flags        <= {(product[MSB:0] == '0), product[MSB],
                                (|product[2*DATA_W-1:DATA_W]), 1'b0};
               wb_valid     <= 1'b1;
               wb_addr      <= mul_rdst;
               wb_data      <= product[MSB:0];
               state        <= ST_IDLE;
               instr_ready  <= 1'b1;
            end
            default: begin
               state       <= ST_IDLE;
               instr_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_exec_unit.sv
// Self-checking bench for seq_exec_unit: directed scenarios plus random instructions
// compared against an arithmetic reference model of the register file and flags.
module tb_seq_exec_unit;

   localparam int     W    = 16;
   localparam longint MASK = (longint'(1) << W) - 1;
   localparam longint SMAX = (longint'(1) << (W - 1)) - 1;
   localparam longint SMIN = -(longint'(1) << (W - 1));

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic [31:0]   instr;
   logic          instr_valid, instr_ready, wb_valid, err;
   logic [4:0]    wb_addr, dbg_addr;
   logic [W-1:0]  wb_data, dbg_data, sgpr;
   logic [3:0]    flags;

   logic [31:0]   instr_s;
   logic          valid_s, ready_s, wbv_s, err_s;
   logic [4:0]    wba_s, dbg_addr_s;
   logic [W-1:0]  wbd_s, dbg_data_s, sgpr_s;
   logic [3:0]    flags_s;

   seq_exec_unit #(.DATA_W(W), .NREG(32)) u_dut (
      .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .wb_valid(wb_valid), .wb_addr(wb_addr),
      .wb_data(wb_data), .flags(flags), .err(err), .dbg_addr(dbg_addr),
      .dbg_data(dbg_data), .sgpr(sgpr)
   );

   seq_exec_unit #(.DATA_W(W), .NREG(8)) u_small (
      .clk(clk), .rst_n(rst_n), .instr(instr_s), .instr_valid(valid_s),
      .instr_ready(ready_s), .wb_valid(wbv_s), .wb_addr(wba_s),
      .wb_data(wbd_s), .flags(flags_s), .err(err_s), .dbg_addr(dbg_addr_s),
      .dbg_data(dbg_data_s), .sgpr(sgpr_s)
   );

   int total = 0;
   int bad   = 0;

   longint     m_gpr [32];
   longint     m_sgpr;
   logic [3:0] m_flags;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] enc_i(input int op, input int rd, input int r1, input int imm);
      return {op[4:0], rd[4:0], r1[4:0], 1'b1, imm[15:0]};
   endfunction

   function automatic logic [31:0] enc_r(input int op, input int rd, input int r1, input int r2);
      return {op[4:0], rd[4:0], r1[4:0], 1'b0, r2[4:0], 11'b0};
   endfunction

   function automatic longint sx(input longint x);
      return (x > SMAX) ? x - (longint'(1) << W) : x;
   endfunction

   task automatic model_reset();
      foreach (m_gpr[i]) m_gpr[i] = 0;
      m_sgpr  = 0;
      m_flags = 4'b0000;
   endtask

   // Reference semantics for the 32-register instance.
   task automatic model_exec(input logic [31:0] ins, output bit ex_wb, output int ex_addr,
                             output longint ex_data, output bit ex_err, output bit ex_mul);
      int op, rd, r1, r2;
      bit im, c, v;
      longint a, b, res, full, sr;
      op = int'(ins[31:27]);
      rd = int'(ins[26:22]);
      r1 = int'(ins[21:17]);
      im = ins[16];
      r2 = int'(ins[15:11]);
      ex_wb = 0; ex_err = 0; ex_mul = 0; ex_addr = rd; ex_data = 0;
      if (op > 11) begin
         ex_err = 1;
         return;
      end
      a = m_gpr[r1];
      b = im ? (longint'(ins[15:0]) & MASK) : m_gpr[r2];
      c = 0; v = 0; res = 0;
      case (op)
         0: res = m_sgpr;
         1: res = im ? b : a;
         2: begin
            full = a + b; res = full & MASK; c = (full > MASK);
            sr = sx(a) + sx(b); v = (sr > SMAX) || (sr < SMIN);
         end
         3: begin
            res = (a - b) & MASK; c = (a < b);
            sr = sx(a) - sx(b); v = (sr > SMAX) || (sr < SMIN);
         end
         4: begin
            full = a * b; res = full & MASK; m_sgpr = full >> W;
            c = (m_sgpr != 0); ex_mul = 1;
         end
         5:  res = a | b;
         6:  res = a & b;
         7:  res = a ^ b;
         8:  res = ~(a ^ b) & MASK;
         9:  res = ~(a & b) & MASK;
         10: res = ~(a | b) & MASK;
         default: res = (im ? ~b : ~a) & MASK;
      endcase
      m_gpr[rd] = res;
      ex_wb = 1;
      ex_data = res;
      if (op != 0) m_flags = {res == 0, ((res >> (W - 1)) & 1) == 1, c, v};
   endtask

   task automatic chk_reg(input string tag, input int idx, input longint val);
      dbg_addr = idx[4:0];
      #1;
      chk(tag, 64'(dbg_data), 64'(val));
   endtask

   task automatic check_out(input string tag, input bit ex_wb, input int ex_addr,
                            input longint ex_data, input bit ex_err);
      chk({tag, "_wb_valid"}, 64'(wb_valid), 64'(ex_wb));
      if (ex_wb) begin
         chk({tag, "_wb_addr"}, 64'(wb_addr), 64'(ex_addr));
         chk({tag, "_wb_data"}, 64'(wb_data), 64'(ex_data));
      end
      chk({tag, "_err"}, 64'(err), 64'(ex_err));
      chk({tag, "_flags"}, 64'(flags), 64'(m_flags));
      chk({tag, "_sgpr"}, 64'(sgpr), 64'(m_sgpr));
      if (ex_wb) chk_reg({tag, "_dbg"}, ex_addr, m_gpr[ex_addr]);
   endtask

   // Issue one instruction on the big instance and check its write-back.
   task automatic run(input string tag, input logic [31:0] ins);
      bit ex_wb, ex_err, ex_mul;
      int ex_addr, n;
      longint ex_data;
      instr = ins;
      instr_valid = 1'b1;
      n = 0;
      while (instr_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_ready"}, 64'(instr_ready), 64'(1));
      model_exec(ins, ex_wb, ex_addr, ex_data, ex_err, ex_mul);
      @(negedge clk);
      instr_valid = 1'b0;
      if (ex_mul) begin
         n = 0;
         while (instr_ready !== 1'b1 && n < 100) begin
            chk({tag, "_busy_no_wb"}, 64'(wb_valid), 64'(0));
            @(negedge clk);
            n++;
         end
         chk({tag, "_busy_cycles"}, 64'(n), 64'(W + 1));
      end
      check_out(tag, ex_wb, ex_addr, ex_data, ex_err);
   endtask

   task automatic small_issue(input logic [31:0] ins);
      chk("small_ready", 64'(ready_s), 64'(1));
      instr_s = ins;
      valid_s = 1'b1;
      @(negedge clk);
      valid_s = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      bit ex_wb, ex_err, ex_mul;
      int ex_addr, n, op, rd, r1, r2;
      longint ex_data;
      logic [31:0] ins;
      int specials [4];
      int iv;

      specials = '{32'h0000FFFF, 32'h00008000, 32'h00007FFF, 32'h00000001};
      rst_n = 1'b0;
      instr = '0; instr_valid = 1'b0; dbg_addr = '0;
      instr_s = '0; valid_s = 1'b0; dbg_addr_s = '0;
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Reset state
      chk("rst_ready", 64'(instr_ready), 64'(1));
      chk("rst_wb_valid", 64'(wb_valid), 64'(0));
      chk("rst_wb_addr", 64'(wb_addr), 64'(0));
      chk("rst_wb_data", 64'(wb_data), 64'(0));
      chk("rst_err", 64'(err), 64'(0));
      chk("rst_flags", 64'(flags), 64'(0));
      chk("rst_sgpr", 64'(sgpr), 64'(0));
      chk("rst_small_flags", 64'(flags_s), 64'(0));
      chk("rst_small_sgpr", 64'(sgpr_s), 64'(0));
      chk_reg("rst_r5", 5, 0);
      chk_reg("rst_r31", 31, 0);

      // Back-to-back dependent issue
      run("mov_r1", enc_i(1, 1, 0, 'h1234));
      run("add_r2", enc_i(2, 2, 1, 'h0001));
      chk_reg("r2_const", 2, 'h1235);
      chk("add_r2_flags_const", 64'(flags), 64'(4'b0000));

      // Carry/zero and signed overflow boundaries
      run("mov_r3", enc_i(1, 3, 0, 'hFFFF));
      run("add_r4", enc_i(2, 4, 3, 'h0001));
      chk("r4_flags_const", 64'(flags), 64'(4'b1010));
      run("mov_r5", enc_i(1, 5, 0, 'h7FFF));
      run("add_r6", enc_i(2, 6, 5, 'h0001));
      chk("r6_flags_const", 64'(flags), 64'(4'b0101));
      chk_reg("r6_const", 6, 'h8000);

      // Multiply then movsgpr
      run("mov_r2b", enc_i(1, 2, 0, 'h0100));
      run("mul_r7", enc_r(4, 7, 1, 2));
      chk_reg("r7_const", 7, 'h3400);
      chk("mul_sgpr_const", 64'(sgpr), 64'('h0012));
      chk("mul_flags_const", 64'(flags), 64'(4'b0010));
      run("movsgpr_r8", enc_i(0, 8, 0, 0));
      chk_reg("r8_const", 8, 'h0012);

      // Dependent add held while the multiplier is busy
      instr = enc_r(4, 10, 1, 2);
      instr_valid = 1'b1;
      model_exec(instr, ex_wb, ex_addr, ex_data, ex_err, ex_mul);
      @(negedge clk);
      instr = enc_i(2, 9, 10, 'h0001);
      n = 0;
      while (instr_ready !== 1'b1 && n < 100) begin
         chk("held_no_wb", 64'(wb_valid), 64'(0));
         chk_reg("held_no_early_write", 9, m_gpr[9]);
         @(negedge clk);
         n++;
      end
      chk("held_accept_cycle", 64'(n + 1), 64'(W + 2));
      check_out("held_mul", ex_wb, ex_addr, ex_data, ex_err);
      model_exec(instr, ex_wb, ex_addr, ex_data, ex_err, ex_mul);
      @(negedge clk);
      instr_valid = 1'b0;
      check_out("held_add", ex_wb, ex_addr, ex_data, ex_err);
      chk_reg("r9_const", 9, 'h3401);

      // Illegal opcode on the full-size instance
      run("illegal_op", {5'b11111, 5'd3, 5'd1, 1'b1, 16'h0042});
      chk_reg("illegal_op_r3", 3, 'hFFFF);
      @(negedge clk);
      chk("illegal_err_one_cycle", 64'(err), 64'(0));

      // Register-index range checks on the 8-register instance
      small_issue(enc_i(1, 1, 0, 'h0055));
      chk("s_mov_wbv", 64'(wbv_s), 64'(1));
      chk("s_mov_wbd", 64'(wbd_s), 64'('h55));
      small_issue(enc_i(1, 9, 0, 'h0077));
      chk("s_rdst9_err", 64'(err_s), 64'(1));
      chk("s_rdst9_no_wb", 64'(wbv_s), 64'(0));
      dbg_addr_s = 5'd1; #1;
      chk("s_r1_kept", 64'(dbg_data_s), 64'('h55));
      dbg_addr_s = 5'd9; #1;
      chk("s_dbg_oob", 64'(dbg_data_s), 64'(0));
      @(negedge clk);
      chk("s_err_pulse_end", 64'(err_s), 64'(0));
      small_issue(enc_r(2, 2, 1, 10));
      chk("s_rsrc2_err", 64'(err_s), 64'(1));
      chk("s_rsrc2_no_wb", 64'(wbv_s), 64'(0));
      small_issue(enc_r(1, 2, 8, 0));
      chk("s_rsrc1_err", 64'(err_s), 64'(1));
      small_issue(enc_i(2, 2, 1, 'hF800));
      chk("s_imm_alias_err", 64'(err_s), 64'(0));
      chk("s_imm_alias_wbv", 64'(wbv_s), 64'(1));
      chk("s_imm_alias_wba", 64'(wba_s), 64'(2));
      chk("s_imm_alias_wbd", 64'(wbd_s), 64'('hF855));
      chk("s_imm_alias_flags", 64'(flags_s), 64'(4'b0100));
      dbg_addr_s = 5'd2; #1;
      chk("s_r2", 64'(dbg_data_s), 64'('hF855));

      // Random instructions against the model
      for (int k = 0; k < 8; k++) run("seed", enc_i(1, k, 0, int'($urandom_range(0, 65535))));
      for (int k = 0; k < 250; k++) begin
         op = int'($urandom_range(0, 13));
         if ($urandom_range(0, 9) == 0) op = 31;
         rd = int'($urandom_range(0, 7));
         r1 = int'($urandom_range(0, 7));
         r2 = int'($urandom_range(0, 7));
         iv = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)]
                                           : int'($urandom_range(0, 65535));
         ins = ($urandom_range(0, 1) == 1) ? enc_i(op, rd, r1, iv) : enc_r(op, rd, r1, r2);
         run("rand", ins);
      end

      // Reset in the fifth multiply cycle aborts the operation
      run("pre_abort_r1", enc_i(1, 1, 0, 'h1234));
      run("pre_abort_r2", enc_i(1, 2, 0, 'h0100));
      instr = enc_r(4, 12, 1, 2);
      instr_valid = 1'b1;
      @(negedge clk);
      instr_valid = 1'b0;
      chk("abort_busy", 64'(instr_ready), 64'(0));
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort_ready", 64'(instr_ready), 64'(1));
      chk("abort_sgpr", 64'(sgpr), 64'(0));
      chk("abort_flags", 64'(flags), 64'(0));
      chk_reg("abort_r1", 1, 0);
      chk_reg("abort_r12", 12, 0);
      for (int k = 0; k < 20; k++) begin
         chk("abort_no_wb", 64'(wb_valid), 64'(0));
         @(negedge clk);
      end
      chk_reg("abort_r12_late", 12, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
